// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
//
// Purpose:
//   Runs the two-pulse INTA handshake of an 8259-style interrupt controller.
//   - Picks the highest-priority unmasked request under rotating priority.
//   - Blocks any request that would not preempt the current in-service level
//     (fully nested mode).
//   - Raises INT toward the CPU.
//   - On the first INTA pulse, latches the acknowledged level and pulses the
//     ISR-set and IRR-clear strobes.
//   - On the second INTA pulse, drives the vector byte.
//   - Optionally clears the in-service bit on exit when auto-EOI is enabled.
//
// Ports:
//   clk              system clock, rising-edge active
//   reset            synchronous, active-high
//   int_ack_n        CPU INTA, active-low, already synchronised to clk
//   irr              interrupt request register
//   int_mask         OCW1 mask (1 = level masked)
//   isr              in-service register
//   priority_rotate  level that currently holds the lowest priority
//   vector_base      ICW2 bits T7-T3
//   auto_eoi         ICW4 AEOI enable
//   INT              registered interrupt request to the CPU
//   set_isr          one-cycle one-hot strobe that sets the in-service bit
//   clear_IRR        one-cycle one-hot strobe that clears the request bit
//   auto_eoi_clear   one-cycle one-hot strobe that clears in-service under AEOI
//   vector_data      vector byte, valid only while vector_data_en is high
//   vector_data_en   drive enable for vector_data (second INTA pulse)
//   busy             high whenever an acknowledge sequence is in progress
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_ack_n,
  input  logic [7:0] irr,
  input  logic [7:0] int_mask,
  input  logic [7:0] isr,
  input  logic [2:0] priority_rotate,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  output logic       INT,
  output logic [7:0] set_isr,
  output logic [7:0] clear_IRR,
  output logic [7:0] auto_eoi_clear,
  output logic [7:0] vector_data,
  output logic       vector_data_en,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       int_ack_n_q;
  logic       int_q, int_d;
  logic [7:0] set_q, set_d;
  logic [7:0] aeoi_q, aeoi_d;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;

  // ---------------------------------------------------------------------------
  // INTA edge detection against the registered copy of int_ack_n.
  // ---------------------------------------------------------------------------
  logic ack_fall, ack_rise;

  assign ack_fall = int_ack_n_q & ~int_ack_n;
  assign ack_rise = ~int_ack_n_q & int_ack_n;

  // ---------------------------------------------------------------------------
  // Priority resolution.
  // The scan walks ranks from highest priority (rank 0) downward. The level
  // holding rank r is priority_rotate + 1 + r (mod 8). The first candidate hit
  // is the winner. The first in-service bit hit sets the nesting limit.
  // ---------------------------------------------------------------------------
  logic [7:0] cand;
  logic [2:0] scan_level;
  logic       win_found, isr_found;
  logic [2:0] win_level, win_rank, isr_rank;
  logic       valid_win;

  assign cand = irr & ~int_mask;

  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise a path
    // that never assigns it would infer a latch.
    scan_level = '0;
    win_found  = 1'b0;
    win_level  = '0;
    win_rank   = '0;
    isr_found  = 1'b0;
    isr_rank   = '0;
    for (int r = 0; r < 8; r++) begin
      scan_level = priority_rotate + 3'd1 + 3'(r);
      if (!win_found && cand[scan_level]) begin
        win_found = 1'b1;
        win_level = scan_level;
        win_rank  = 3'(r);
      end
      if (!isr_found && isr[scan_level]) begin
        isr_found = 1'b1;
        isr_rank  = 3'(r);
      end
    end
  end

  // A winner must strictly outrank everything already in service; an empty
  // ISR imposes no limit.
  assign valid_win = win_found && (!isr_found || (win_rank < isr_rank));

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge
    // values, so ordering between sequential blocks cannot matter.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic.
  // A falling INTA edge in ACK1 or ACK2 is ignored. A falling edge in IDLE
  // always starts a sequence, even with INT low (the spurious path).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ack_fall) state_d = ACK1;
      ACK1:    if (ack_rise) state_d = WAIT2;
      WAIT2:   if (ack_fall) state_d = ACK2;
      ACK2:    if (ack_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (combinational from the current state).
  // ---------------------------------------------------------------------------
  always_comb begin
    busy           = (state_q != IDLE);
    vector_data_en = (state_q == ACK2);
    vector_data    = (state_q == ACK2) ? {vector_base, ack_level_q} : 8'h00;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state.
  // INT is suppressed on the acknowledging edge, so it drops in the same clock
  // edge that enters ACK1. The acknowledged level is frozen at that edge and
  // held until the sequence completes, whatever the request inputs do.
  // ---------------------------------------------------------------------------
  always_comb begin
    int_d       = (state_q == IDLE) && valid_win && !ack_fall;
    set_d       = '0;
    aeoi_d      = '0;
    ack_level_d = ack_level_q;
    spurious_d  = spurious_q;

    if ((state_q == IDLE) && ack_fall) begin
      ack_level_d = valid_win ? win_level : SPURIOUS_LEVEL;
      spurious_d  = !valid_win;
      if (valid_win) begin
        set_d = 8'd1 << win_level;
      end
    end

    if ((state_q == ACK2) && ack_rise && auto_eoi && !spurious_q) begin
      aeoi_d = 8'd1 << ack_level_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. Reset drops any pulse that is in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      int_ack_n_q <= 1'b1;
      int_q       <= 1'b0;
      set_q       <= '0;
      aeoi_q      <= '0;
      ack_level_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      int_ack_n_q <= int_ack_n;
      int_q       <= int_d;
      set_q       <= set_d;
      aeoi_q      <= aeoi_d;
      ack_level_q <= ack_level_d;
      spurious_q  <= spurious_d;
    end
  end

  assign INT            = int_q;
  assign set_isr        = set_q;
  assign clear_IRR      = set_q;
  assign auto_eoi_clear = aeoi_q;

endmodule
